// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared encodings, state enum and size helpers for mem_access_unit
package mau_pkg;

  localparam logic [1:0] KIND_FETCH   = 2'd0;
  localparam logic [1:0] KIND_LOAD    = 2'd1;
  localparam logic [1:0] KIND_STORE   = 2'd2;
  localparam logic [1:0] KIND_ILLEGAL = 2'd3;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_FAULT    = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ISSUE2,
    WAIT2,
    RESP
  } state_e;

  // Byte-lane mask for an access size taken from funct3[1:0]
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return MASK_B;
      2'd1:    return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

  // Access size in bytes for funct3[1:0]
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// rtl/mau_lane_align.sv - store lane shift/byte-enable and load extract/extend/merge
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_lo_i,
  input  logic [31:0] rdata_hi_i,
  output logic [3:0]  be_lo_o,
  output logic [3:0]  be_hi_o,
  output logic [31:0] wdata_lo_o,
  output logic [31:0] wdata_hi_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [31:0] rd_shift;

  // Treat the two adjacent words as one 64-bit window so split and single accesses share one path
  always_comb begin
    be_wide    = {4'b0000, size_mask(funct3_i[1:0])} << off_i;
    wd_wide    = {32'h0, wdata_i} << {off_i, 3'b000};
    rd_shift   = 32'({rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000});
    be_lo_o    = be_wide[3:0];
    be_hi_o    = be_wide[7:4];
    wdata_lo_o = wd_wide[31:0];
    wdata_hi_o = wd_wide[63:32];
    case (funct3_i)
      F3_B:    rdata_o = {{24{rd_shift[7]}}, rd_shift[7:0]};
      F3_BU:   rdata_o = {24'h0, rd_shift[7:0]};
      F3_H:    rdata_o = {{16{rd_shift[15]}}, rd_shift[15:0]};
      F3_HU:   rdata_o = {16'h0, rd_shift[15:0]};
      default: rdata_o = rd_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - handshake memory sequencer; MAU_MISALIGN_SPLIT_EN enables split misaligned load/store
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [3:0]        mem_byteen,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  state_e             state_q, state_d;
  logic [1:0]         kind_q, kind_d;
  logic [2:0]         f3_q, f3_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         err_q, err_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               split_q, split_d;

  logic [2:0]         acc_f3;
  logic               acc_illegal, acc_fault, acc_misal, acc_split;
  logic [1:0]         acc_err;
  logic [ADDR_W-3:0]  word_addr;
  logic [3:0]         be_lo, be_hi;
  logic [31:0]        wd_lo, wd_hi, ld_data, rd_lo, rd_hi;

`ifdef MAU_MISALIGN_SPLIT_EN
  logic [2:0] acc_end;
  logic       acc_spans, acc_top_word;
  assign acc_end      = {1'b0, req_addr[1:0]} + size_bytes(acc_f3[1:0]);
  assign acc_spans    = acc_end > 3'd4;
  assign acc_top_word = &req_addr[ADDR_W-1:2];
`endif

  // Classify the incoming request; priority is illegal > fault > misaligned
  always_comb begin
    acc_f3      = (req_kind == KIND_FETCH) ? F3_W : req_funct3;
    acc_err     = ERR_OK;
    acc_split   = 1'b0;
    case (req_kind)
      KIND_FETCH: acc_illegal = 1'b0;
      KIND_LOAD:  acc_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      KIND_STORE: acc_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
      default:    acc_illegal = 1'b1;
    endcase
    acc_fault = (req_addr >> ADDR_W) != '0;
    case (acc_f3[1:0])
      2'd0:    acc_misal = 1'b0;
      2'd1:    acc_misal = req_addr[0];
      default: acc_misal = req_addr[1:0] != 2'b00;
    endcase
    if (acc_illegal) begin
      acc_err = ERR_ILLEGAL;
    end else if (acc_fault) begin
      acc_err = ERR_FAULT;
    end else if (acc_misal) begin
`ifdef MAU_MISALIGN_SPLIT_EN
      if (req_kind == KIND_FETCH) begin
        acc_err = ERR_MISALIGN;
      end else if (acc_spans && acc_top_word) begin
        acc_err = ERR_FAULT;
      end else begin
        acc_split = acc_spans;
      end
`else
      acc_err = ERR_MISALIGN;
`endif
    end
  end

  assign word_addr = addr_q[ADDR_W-1:2];
  assign rd_lo     = (state_q == WAIT2) ? lo_q : mem_rdata;
  assign rd_hi     = (state_q == WAIT2) ? mem_rdata : 32'h0;

  mau_lane_align u_lane (
    .funct3_i   (f3_q),
    .off_i      (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rdata_lo_i (rd_lo),
    .rdata_hi_i (rd_hi),
    .be_lo_o    (be_lo),
    .be_hi_o    (be_hi),
    .wdata_lo_o (wd_lo),
    .wdata_hi_o (wd_hi),
    .rdata_o    (ld_data)
  );

  // Next-state logic and state-decoded outputs; memory strobes exist only in ISSUE/ISSUE2
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    data_d     = data_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    split_d    = split_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_err    = ERR_OK;
    mem_addr   = '0;
    mem_rden   = 1'b0;
    mem_wren   = 1'b0;
    mem_byteen = 4'b0000;
    mem_wdata  = 32'h0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          kind_d  = req_kind;
          f3_d    = acc_f3;
          addr_d  = req_addr[ADDR_W-1:0];
          wdata_d = req_wdata[31:0];
          err_d   = acc_err;
          split_d = acc_split;
          data_d  = 32'h0;
          cnt_d   = '0;
          state_d = (acc_err != ERR_OK) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_addr = word_addr;
        if (kind_q == KIND_STORE) begin
          mem_wren   = 1'b1;
          mem_byteen = be_lo;
          mem_wdata  = wd_lo;
          state_d    = split_q ? ISSUE2 : RESP;
        end else begin
          mem_rden   = 1'b1;
          mem_byteen = MASK_W;
          cnt_d      = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          if (split_q) begin
            lo_d    = mem_rdata;
            state_d = ISSUE2;
          end else begin
            data_d  = ld_data;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ISSUE2: begin
        mem_addr = word_addr + (ADDR_W-2)'(1);
        if (kind_q == KIND_STORE) begin
          mem_wren   = 1'b1;
          mem_byteen = be_hi;
          mem_wdata  = wd_hi;
          state_d    = RESP;
        end else begin
          mem_rden   = 1'b1;
          mem_byteen = MASK_W;
          cnt_d      = '0;
          state_d    = WAIT2;
        end
      end
      WAIT2: begin
        if (cnt_q == CNT_LAST) begin
          data_d  = ld_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = XLEN'(data_q);
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      kind_q  <= KIND_FETCH;
      f3_q    <= F3_W;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= ERR_OK;
      data_q  <= 32'h0;
      lo_q    <= 32'h0;
      cnt_q   <= '0;
      split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      data_q  <= data_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      split_q <= split_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a latency-2 RAM model
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int XLEN = 32;
  localparam int ADDR_W = 16;
  localparam int LAT = 2;
  localparam int RL = 2 + LAT;
  localparam int SL = 3 + 2 * LAT;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_kind;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_data;
  logic [1:0]        rsp_err;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_rden;
  logic              mem_wren;
  logic [3:0]        mem_byteen;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_byteen(mem_byteen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM model: read data appears LAT edges after the address is sampled
  logic [31:0] ram [0:1023];
  logic [31:0] pipe [0:LAT-1];
  assign mem_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      ram[4]     <= 32'h00000013;
      ram[8]     <= 32'h80FF7F01;
      ram[12]    <= 32'h11223344;
      ram[16]    <= 32'h44332211;
      ram[17]    <= 32'h88776655;
    end else if (mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteen[b]) ram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    pipe[0] <= mem_rden ? ram[mem_addr[9:0]] : 32'hDEADBEEF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log
  logic [13:0] rd_q [$];
  logic [3:0]  be_q [$];
  logic [31:0] wd_q [$];
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rden) rd_q.push_back(mem_addr);
      if (mem_wren) begin
        be_q.push_back(mem_byteen);
        wd_q.push_back(mem_wdata);
      end
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [1:0]  err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb [$];
  exp_t sb_e;

  // Response side of the scoreboard
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        check_eq("stray_rsp", 1, 0);
      end else begin
        sb_e = sb.pop_front();
        check_eq({sb_e.tag, "_data"}, rsp_data, sb_e.data);
        check_eq({sb_e.tag, "_err"}, rsp_err, sb_e.err);
        check_eq({sb_e.tag, "_lat"}, cyc - sb_e.acc, sb_e.lat);
        check_eq({sb_e.tag, "_ready_in_resp"}, req_ready, 0);
      end
    end
  end

  task automatic do_req(input string tag, input logic [1:0] kind, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic [1:0] exp_err, input int exp_lat,
                        input int exp_nrd, input logic [13:0] exp_rd0, input logic [13:0] exp_rd1,
                        input int exp_nwr, input logic [3:0] exp_be0, input logic [31:0] exp_wd0,
                        input logic [3:0] exp_be1, input logic [31:0] exp_wd1);
    int   rd_base, wr_base, guard;
    exp_t e;
    @(negedge clk);
    check_eq({tag, "_ready"}, req_ready, 1);
    rd_base = rd_q.size();
    wr_base = be_q.size();
    req_kind = kind; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    e.tag = tag; e.data = exp_data; e.err = exp_err; e.lat = exp_lat; e.acc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_kind = 2'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    check_eq({tag, "_busy"}, req_ready, 0);
    guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_rsp_seen"}, sb.size(), 0);
    sb.delete();
    check_eq({tag, "_nrd"}, rd_q.size() - rd_base, exp_nrd);
    if (exp_nrd > 0 && rd_q.size() > rd_base) check_eq({tag, "_rd0"}, rd_q[rd_base], exp_rd0);
    if (exp_nrd > 1 && rd_q.size() > rd_base + 1) check_eq({tag, "_rd1"}, rd_q[rd_base+1], exp_rd1);
    check_eq({tag, "_nwr"}, be_q.size() - wr_base, exp_nwr);
    if (exp_nwr > 0 && be_q.size() > wr_base) begin
      check_eq({tag, "_be0"}, be_q[wr_base], exp_be0);
      check_eq({tag, "_wd0"}, wd_q[wr_base], exp_wd0);
    end
    if (exp_nwr > 1 && be_q.size() > wr_base + 1) begin
      check_eq({tag, "_be1"}, be_q[wr_base+1], exp_be1);
      check_eq({tag, "_wd1"}, wd_q[wr_base+1], exp_wd1);
    end
    @(negedge clk);
    check_eq({tag, "_ready_after"}, req_ready, 1);
  endtask

  task automatic rd_req(input string tag, input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] exp_data, input int lat, input int nrd,
                        input logic [13:0] a0, input logic [13:0] a1);
    do_req(tag, kind, f3, addr, 32'h0, exp_data, ERR_OK, lat, nrd, a0, a1, 0, 4'h0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic wr_req(input string tag, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input int nwr, input logic [3:0] be0, input logic [31:0] wd0,
                        input logic [3:0] be1, input logic [31:0] wd1);
    do_req(tag, KIND_STORE, f3, addr, wd, 32'h0, ERR_OK, lat, 0, 14'h0, 14'h0, nwr, be0, wd0, be1, wd1);
  endtask

  task automatic err_req(input string tag, input logic [1:0] kind, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [1:0] err);
    do_req(tag, kind, f3, addr, 32'h5A5A5A5A, 32'h0, err, 1, 0, 14'h0, 14'h0, 0, 4'h0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit, required finish");
    $fatal(1);
  end

  int seen;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_kind = 2'd0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_rden", mem_rden, 0);
    check_eq("rst_wren", mem_wren, 0);
    check_eq("rst_byteen", mem_byteen, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    rst = 1'b0;

    rd_req("fetch10", KIND_FETCH, 3'd7, 32'h10, 32'h00000013, RL, 1, 14'd4, 14'd0);
    rd_req("lb22", KIND_LOAD, F3_B, 32'h22, 32'hFFFFFFFF, RL, 1, 14'd8, 14'd0);
    rd_req("lbu23", KIND_LOAD, F3_BU, 32'h23, 32'h00000080, RL, 1, 14'd8, 14'd0);
    rd_req("lh22", KIND_LOAD, F3_H, 32'h22, 32'hFFFF80FF, RL, 1, 14'd8, 14'd0);
    rd_req("lb21", KIND_LOAD, F3_B, 32'h21, 32'h0000007F, RL, 1, 14'd8, 14'd0);
    rd_req("lhu20", KIND_LOAD, F3_HU, 32'h20, 32'h00007F01, RL, 1, 14'd8, 14'd0);
    rd_req("lw20", KIND_LOAD, F3_W, 32'h20, 32'h80FF7F01, RL, 1, 14'd8, 14'd0);

    wr_req("sb31", F3_B, 32'h31, 32'h000000AB, 2, 1, 4'b0010, 32'h0000AB00, 4'h0, 32'h0);
    check_eq("sb31_ram", ram[12], 32'h1122AB44);
    wr_req("sw34", F3_W, 32'h34, 32'hCAFEF00D, 2, 1, 4'b1111, 32'hCAFEF00D, 4'h0, 32'h0);
    wr_req("sh36", F3_H, 32'h36, 32'h00001234, 2, 1, 4'b1100, 32'h12340000, 4'h0, 32'h0);
    rd_req("lw34", KIND_LOAD, F3_W, 32'h34, 32'h1234F00D, RL, 1, 14'hD, 14'd0);

`ifdef MAU_MISALIGN_SPLIT_EN
    rd_req("lw42_split", KIND_LOAD, F3_W, 32'h42, 32'h66554433, SL, 2, 14'h10, 14'h11);
    rd_req("lh41_inword", KIND_LOAD, F3_H, 32'h41, 32'h00003322, RL, 1, 14'h10, 14'd0);
    wr_req("sh53_split", F3_H, 32'h53, 32'h0000CDEF, 3, 2, 4'b1000, 32'hEF000000, 4'b0001, 32'h000000CD);
    rd_req("lw50", KIND_LOAD, F3_W, 32'h50, 32'hEF000000, RL, 1, 14'h14, 14'd0);
    rd_req("lw54", KIND_LOAD, F3_W, 32'h54, 32'h000000CD, RL, 1, 14'h15, 14'd0);
    err_req("lw_fffe_top", KIND_LOAD, F3_W, 32'h0000FFFE, ERR_FAULT);
`else
    err_req("lw42_mis", KIND_LOAD, F3_W, 32'h42, ERR_MISALIGN);
    err_req("lh41_mis", KIND_LOAD, F3_H, 32'h41, ERR_MISALIGN);
    err_req("sh53_mis", KIND_STORE, F3_H, 32'h53, ERR_MISALIGN);
    rd_req("lw50", KIND_LOAD, F3_W, 32'h50, 32'h00000000, RL, 1, 14'h14, 14'd0);
    rd_req("lw54", KIND_LOAD, F3_W, 32'h54, 32'h00000000, RL, 1, 14'h15, 14'd0);
    err_req("lw_fffe_mis", KIND_LOAD, F3_W, 32'h0000FFFE, ERR_MISALIGN);
`endif

    err_req("lw_fault", KIND_LOAD, F3_W, 32'h00010000, ERR_FAULT);
    err_req("ld_f3_011", KIND_LOAD, 3'b011, 32'h20, ERR_ILLEGAL);
    err_req("kind3", KIND_ILLEGAL, F3_W, 32'h10, ERR_ILLEGAL);
    err_req("fetch_mis", KIND_FETCH, F3_W, 32'h12, ERR_MISALIGN);
    err_req("kind3_over_fault", KIND_ILLEGAL, F3_W, 32'h00010001, ERR_ILLEGAL);
    err_req("fault_over_mis", KIND_LOAD, F3_W, 32'h00010002, ERR_FAULT);
    err_req("st_f3_bu", KIND_STORE, F3_BU, 32'h30, ERR_ILLEGAL);

    for (int ab = 1; ab <= 2; ab++) begin
      @(negedge clk);
      req_kind = KIND_FETCH; req_funct3 = 3'd0; req_addr = 32'h10; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (ab == 2) begin
        @(posedge clk); #1;
      end
      check_eq($sformatf("abort%0d_rden_before", ab), mem_rden, (ab == 1));
      rst = 1'b1;
      #1;
      check_eq($sformatf("abort%0d_rden", ab), mem_rden, 0);
      check_eq($sformatf("abort%0d_rsp_valid", ab), rsp_valid, 0);
      check_eq($sformatf("abort%0d_ready", ab), req_ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      check_eq($sformatf("abort%0d_no_rsp", ab), seen, 0);
      check_eq($sformatf("abort%0d_ready_after", ab), req_ready, 1);
    end

    rd_req("fetch_post_abort", KIND_FETCH, F3_W, 32'h10, 32'h00000013, RL, 1, 14'd4, 14'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised, handshake-driven memory sequencer that replaces the core's fixed-count WAIT_* memory delays for instruction fetch, loads and stores. It sits between the multi-cycle core FSM and the word-wide system RAM. It handles byte/half/word lanes, sign extension, range checks and misalignment, with a configurable RAM read latency. It reports completion with a one-cycle response pulse.

## Interface
- `XLEN`, 32: core data/address width.
- `ADDR_W`, 16: byte-address width of the RAM; bytes at `2**ADDR_W` and above fault.
- `MEM_LATENCY`, 2: cycles from the RAM sampling an address to `mem_rdata` valid; must be at least 1.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: core request strobe.
- `req_ready` out 1: unit idle; accepts a request this cycle.
- `req_kind` in 2: 0 = fetch, 1 = load, 2 = store; 3 is illegal.
- `req_funct3` in 3: RISC-V width code (LB/LH/LW/LBU/LHU, SB/SH/SW); ignored for fetch.
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out XLEN: extended load or fetch data; 0 for stores and errors.
- `rsp_err` out 2: 0 = ok, 1 = misaligned, 2 = access fault, 3 = illegal kind or funct3.
- `mem_addr` out ADDR_W-2: word address.
- `mem_rden` out 1: RAM read enable.
- `mem_wren` out 1: RAM write enable.
- `mem_byteen` out 4: RAM byte enables.
- `mem_wdata` out 32: lane-shifted write data.
- `mem_rdata` in 32: RAM read data.

## Operation
- States: IDLE, ISSUE, WAIT, ISSUE2, WAIT2, RESP.
- IDLE: `req_ready` is 1. On `req_valid`, the unit captures all `req_*` inputs; the core need not hold them afterwards.
- Error checks are done at acceptance, in priority order: illegal (3) > access fault (2) > misaligned (1).
  - Fetch must be word aligned.
  - Load/store must be naturally aligned unless the macro below is defined.
- An error goes IDLE→RESP with no RAM access.
- ISSUE drives `mem_addr` = addr[ADDR_W-1:2] for one cycle.
  - Read: `mem_rden` = 1, `mem_byteen` = 4'b1111.
  - Write: `mem_wren` = 1, `mem_byteen` = size mask << addr[1:0], `mem_wdata` = wdata << 8*addr[1:0].
- Store: ISSUE→RESP.
- Read: ISSUE→WAIT. WAIT counts MEM_LATENCY cycles, samples `mem_rdata` on its last cycle, then goes to RESP.
- Load data is shifted right by 8*addr[1:0]. B/H are sign-extended; BU/HU are zero-extended.
- RESP: `rsp_valid` = 1 with data and error code, then back to IDLE.
- `mem_rden`, `mem_wren` and `mem_byteen` are 0 outside ISSUE/ISSUE2.

## Timing
- Cycle 0 is the acceptance cycle.
- Error: RESP in cycle 1.
- Store: ISSUE in cycle 1, RESP in cycle 2.
- Read: ISSUE in cycle 1, WAIT in cycles 2..1+MEM_LATENCY, RESP in cycle 2+MEM_LATENCY.
- Split read: RESP in cycle 3+2·MEM_LATENCY. Split store: RESP in cycle 3.
- `req_ready` returns to 1 in the cycle after RESP; there is no back-to-back acceptance during RESP.
- Reset values: state IDLE; `req_ready` 1; every other output 0.
  - Memory strobes are decoded from state, so they drop asynchronously on `rst`.
  - An aborted request produces no response.

## Configuration
- `MAU_MISALIGN_SPLIT_EN` defined:
  - A misaligned load/store that fits in one word uses a single access.
  - One that spans two words does the low word (ISSUE/WAIT) then word+1 (ISSUE2/WAIT2), and merges the bytes.
  - A store split writes only the remaining bytes in ISSUE2.
  - If word+1 is out of range: rsp_err = 2, and no access is made.
- `MAU_MISALIGN_SPLIT_EN` undefined: any misaligned load/store gives rsp_err = 1 and ISSUE2/WAIT2 are unreachable.
- Misaligned fetch is always rsp_err = 1.

## Structure
- `mau_pkg` holds:
  - kind encodings;
  - rsp_err codes;
  - funct3 constants;
  - state enum;
  - size-mask constants.
- `mau_lane_align` is one combinational sub-module that:
  - produces the store shift and byte-enable;
  - extracts and extends load data;
  - does the split merge.

## Test plan
All with MEM_LATENCY = 2.
1. Fetch 0x10, RAM word 4 = 0x00000013 → `mem_addr` = 4, `mem_rden` in cycle 1; `rsp_valid` in cycle 4 with data 0x00000013, err 0.
2. Word 8 = 0x80FF7F01:
   - LB 0x22 → 0xFFFFFFFF.
   - LBU 0x23 → 0x00000080.
   - LH 0x22 → 0xFFFF80FF.
3. SB 0x31, wdata 0x000000AB → `mem_byteen` 4'b0010, `mem_wdata` 0x0000AB00, `rsp_valid` in cycle 2.
4. LW 0x42 with words 0x10/0x11 = 0x44332211/0x88776655:
   - macro undefined → err 1 in cycle 1, no `mem_rden`;
   - macro defined → reads of words 0x10 and 0x11, data 0x66554433 in cycle 7.
5. Error responses, each in cycle 1 with no RAM access:
   - LW 0x00010000 → err 2.
   - Load with funct3 3'b011 → err 3.
   - Kind 3 → err 3.
6. `rst` during WAIT → `mem_rden`/`rsp_valid` go 0 immediately; `req_ready` is 1 after release; no response ever appears for the aborted request.
